// File: rtl/z2_cycle_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | z2_cycle_ctrl_pkg                                                          |
// | Shared Zorro II cycle-state encodings and counter width.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package z2_cycle_ctrl_pkg;

  typedef enum logic [1:0] {
    Z2_IDLE  = 2'd0,
    Z2_START = 2'd1,
    Z2_DATA  = 2'd2,
    Z2_END   = 2'd3
  } z2_state_e;

  localparam int C_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/z2_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | z2_sync                                                                    |
// | Parametrised-depth synchroniser chain with selectable reset value.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module z2_sync #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stages_q;
  logic [DEPTH-1:0] stages_d;

  generate
    if (DEPTH == 1) begin : g_single
      always_comb stages_d = d;
    end else begin : g_chain
      always_comb stages_d = {stages_q[DEPTH-2:0], d};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stages_q <= {DEPTH{RST_VAL}};
    else        stages_q <= stages_d;
  end

  assign q = stages_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/z2_cycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | z2_cycle_ctrl                                                              |
// | Zorro II slave cycle sequencer: strobe sync, target arbitration, DTACK.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module z2_cycle_ctrl
  import z2_cycle_ctrl_pkg::*;
#(
  parameter int               NUM_TGT        = 5,
  parameter int               SYNC_DEPTH     = 2,
  parameter logic [NUM_TGT-1:0] IMM_MASK     = 5'b00001,
  parameter logic [NUM_TGT-1:0] DRIVE_MASK   = 5'b11110,
  parameter int               TIMEOUT_CYCLES = 255
) (
  input  logic               MEMCLK,
  input  logic               RESET_n,
  input  logic               AS_n,
  input  logic               UDS_n,
  input  logic               LDS_n,
  input  logic               RW,
  input  logic [NUM_TGT-1:0] tgt_sel,
  input  logic [NUM_TGT-1:0] tgt_ready,
  output logic               as_n_s,
  output logic               uds_n_s,
  output logic               lds_n_s,
  output logic               rw_s,
  output logic [1:0]         z2_state,
  output logic [NUM_TGT-1:0] cycle_tgt,
  output logic               dtack,
  output logic               timeout,
  output logic               DTACK_n
);

  localparam logic [C_CNT_W-1:0] C_TIMEOUT = C_CNT_W'(TIMEOUT_CYCLES);

  z2_sync #(.DEPTH(SYNC_DEPTH), .RST_VAL(1'b1)) u_sync_as  (.clk(MEMCLK), .rst_n(RESET_n), .d(AS_n),  .q(as_n_s));
  z2_sync #(.DEPTH(SYNC_DEPTH), .RST_VAL(1'b1)) u_sync_uds (.clk(MEMCLK), .rst_n(RESET_n), .d(UDS_n), .q(uds_n_s));
  z2_sync #(.DEPTH(SYNC_DEPTH), .RST_VAL(1'b1)) u_sync_lds (.clk(MEMCLK), .rst_n(RESET_n), .d(LDS_n), .q(lds_n_s));
  z2_sync #(.DEPTH(SYNC_DEPTH), .RST_VAL(1'b1)) u_sync_rw  (.clk(MEMCLK), .rst_n(RESET_n), .d(RW),    .q(rw_s));

  z2_state_e            state_q, state_d;
  logic [NUM_TGT-1:0]   cycle_tgt_q, cycle_tgt_d;
  logic                 dtack_q, dtack_d;
  logic                 timeout_q, timeout_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic                 as_x_q, as_x_d;
  logic [C_CNT_W-1:0]   cnt_inc;
  logic                 to_hit;
  logic                 ack;
  logic [NUM_TGT-1:0]   first_sel;

  // Extra AS stage gates cycle start so UDS/LDS are settled by the time START looks at them.
  always_comb as_x_d = as_n_s;

  always_comb begin
    first_sel = '0;
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if (tgt_sel[i]) begin
        first_sel    = '0;
        first_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cycle_tgt_d = cycle_tgt_q;
    dtack_d     = dtack_q;
    timeout_d   = 1'b0;
    cnt_d       = cnt_q;
    cnt_inc     = cnt_q + 1'b1;
    to_hit      = (C_TIMEOUT != '0) && (cnt_inc == C_TIMEOUT);
    ack         = |(cycle_tgt_q & (IMM_MASK | tgt_ready));

    case (state_q)
      Z2_IDLE: begin
        dtack_d     = 1'b0;
        cnt_d       = '0;
        cycle_tgt_d = '0;
        if (!as_x_q && (|tgt_sel)) begin
          cycle_tgt_d = first_sel;
          state_d     = Z2_START;
        end
      end
      Z2_START: begin
        cnt_d = cnt_inc;
        if (as_n_s) begin
          state_d     = Z2_IDLE;
          cycle_tgt_d = '0;
          cnt_d       = '0;
        end else if (to_hit) begin
          timeout_d = 1'b1;
          state_d   = Z2_END;
        end else if (!uds_n_s || !lds_n_s) begin
          state_d = Z2_DATA;
        end
      end
      Z2_DATA: begin
        cnt_d = cnt_inc;
        if (as_n_s) begin
          state_d     = Z2_IDLE;
          cycle_tgt_d = '0;
          cnt_d       = '0;
        end else if (ack) begin
          dtack_d = 1'b1;
          state_d = Z2_END;
        end else if (to_hit) begin
          timeout_d = 1'b1;
          state_d   = Z2_END;
        end
      end
      Z2_END: begin
        if (as_n_s) begin
          dtack_d     = 1'b0;
          cycle_tgt_d = '0;
          state_d     = Z2_IDLE;
        end
      end
      default: state_d = Z2_IDLE;
    endcase
  end

  always_ff @(posedge MEMCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q     <= Z2_IDLE;
      cycle_tgt_q <= '0;
      dtack_q     <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
      as_x_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cycle_tgt_q <= cycle_tgt_d;
      dtack_q     <= dtack_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
      as_x_q      <= as_x_d;
    end
  end

  assign z2_state  = state_q;
  assign cycle_tgt = cycle_tgt_q;
  assign dtack     = dtack_q;
  assign timeout   = timeout_q;

  // Raw AS_n in the enable lets the pin release as soon as the master ends the cycle.
  assign DTACK_n = (dtack_q && !AS_n && (|(cycle_tgt_q & DRIVE_MASK))) ? 1'b0 : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_z2_cycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_z2_cycle_ctrl                                                           |
// | Directed self-checking bench for z2_cycle_ctrl (DTACK_n pulled up).        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_z2_cycle_ctrl;

  logic       MEMCLK;
  logic       RESET_n;
  logic       AS_n, UDS_n, LDS_n, RW;
  logic [4:0] tgt_sel, tgt_ready;
  logic       as_n_s, uds_n_s, lds_n_s, rw_s;
  logic [1:0] z2_state;
  logic [4:0] cycle_tgt;
  logic       dtack, timeout;
  wire        dtack_n_w;

  pullup (dtack_n_w);

  int errors = 0;
  int checks = 0;

  z2_cycle_ctrl #(
    .NUM_TGT(5), .SYNC_DEPTH(2), .IMM_MASK(5'b00001),
    .DRIVE_MASK(5'b11110), .TIMEOUT_CYCLES(10)
  ) dut (
    .MEMCLK(MEMCLK), .RESET_n(RESET_n),
    .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n), .RW(RW),
    .tgt_sel(tgt_sel), .tgt_ready(tgt_ready),
    .as_n_s(as_n_s), .uds_n_s(uds_n_s), .lds_n_s(lds_n_s), .rw_s(rw_s),
    .z2_state(z2_state), .cycle_tgt(cycle_tgt),
    .dtack(dtack), .timeout(timeout), .DTACK_n(dtack_n_w)
  );

  initial MEMCLK = 1'b0;
  always #5 MEMCLK = ~MEMCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge MEMCLK);
      #1;
    end
  endtask

  initial begin
    RESET_n = 1'b0; AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; RW = 1'b1;
    tgt_sel = '0; tgt_ready = '0;
    #12;
    chk("rst_state",   32'(z2_state),  0);
    chk("rst_dtack",   32'(dtack),     0);
    chk("rst_tgt",     32'(cycle_tgt), 0);
    chk("rst_timeout", 32'(timeout),   0);
    chk("rst_as_s",    32'(as_n_s),    1);
    chk("rst_rw_s",    32'(rw_s),      1);
    chk("rst_dtack_n", 32'(dtack_n_w), 1);
    RESET_n = 1'b1;
    tick(2);

    // Read from immediate target 0
    UDS_n = 1'b0; tgt_sel = 5'b00001; AS_n = 1'b0;
    tick();  chk("t1_as_s_e0", 32'(as_n_s), 1);
    tick();  chk("t1_as_s_e1", 32'(as_n_s), 0);
    tick();  chk("t1_idle_e2", 32'(z2_state), 0);
    tick();  chk("t1_start_e3", 32'(z2_state), 1);
             chk("t1_tgt", 32'(cycle_tgt), 32'h01);
    tick();  chk("t1_data_e4", 32'(z2_state), 2);
             chk("t1_dtack_e4", 32'(dtack), 0);
    tick();  chk("t1_end_e5", 32'(z2_state), 3);
             chk("t1_dtack_e5", 32'(dtack), 1);
             chk("t1_pin_z", 32'(dtack_n_w), 1);
    AS_n = 1'b1; UDS_n = 1'b1; tgt_sel = '0;
    tick(2); chk("t1_end_hold", 32'(z2_state), 3);
             chk("t1_dtack_hold", 32'(dtack), 1);
    tick();  chk("t1_idle", 32'(z2_state), 0);
             chk("t1_dtack_off", 32'(dtack), 0);
             chk("t1_tgt_clr", 32'(cycle_tgt), 0);
    tick(2);

    // Write to ready-driven target 2, sel changes mid-cycle
    RW = 1'b0; LDS_n = 1'b0; tgt_sel = 5'b10100; AS_n = 1'b0;
    tick(2); chk("t2_rw_s", 32'(rw_s), 0);
    tick(2); chk("t2_start", 32'(z2_state), 1);
             chk("t2_tgt", 32'(cycle_tgt), 32'h04);
    tgt_sel = 5'b10000;
    tick();  chk("t2_data", 32'(z2_state), 2);
             chk("t2_tgt_hold", 32'(cycle_tgt), 32'h04);
    tick(5); chk("t2_data_wait", 32'(z2_state), 2);
             chk("t2_no_dtack", 32'(dtack), 0);
    tgt_ready = 5'b00100;
    tick();  chk("t2_end", 32'(z2_state), 3);
             chk("t2_dtack", 32'(dtack), 1);
             chk("t2_pin_low", 32'(dtack_n_w), 0);
    AS_n = 1'b1;
    #1;      chk("t2_pin_release", 32'(dtack_n_w), 1);
    LDS_n = 1'b1; tgt_ready = '0; tgt_sel = '0; RW = 1'b1;
    tick(2); chk("t2_end_hold", 32'(z2_state), 3);
    tick();  chk("t2_idle", 32'(z2_state), 0);
             chk("t2_dtack_off", 32'(dtack), 0);
    tick(2);

    // Target 3 never ready: timeout 10 cycles after START
    UDS_n = 1'b0; tgt_sel = 5'b01000; AS_n = 1'b0;
    tick(4); chk("t3_start", 32'(z2_state), 1);
    tick(9); chk("t3_data", 32'(z2_state), 2);
             chk("t3_no_to", 32'(timeout), 0);
    tick();  chk("t3_to_pulse", 32'(timeout), 1);
             chk("t3_end", 32'(z2_state), 3);
             chk("t3_no_dtack", 32'(dtack), 0);
    tick();  chk("t3_to_clear", 32'(timeout), 0);
             chk("t3_pin_z", 32'(dtack_n_w), 1);
    AS_n = 1'b1; UDS_n = 1'b1; tgt_sel = '0;
    tick(3); chk("t3_idle", 32'(z2_state), 0);
    tick(2);

    // Abort in DATA
    LDS_n = 1'b0; tgt_sel = 5'b00100; AS_n = 1'b0;
    tick(5); chk("t4_data", 32'(z2_state), 2);
    AS_n = 1'b1; LDS_n = 1'b1; tgt_sel = '0;
    tick(2); chk("t4_data_hold", 32'(z2_state), 2);
    tick();  chk("t4_idle", 32'(z2_state), 0);
             chk("t4_no_dtack", 32'(dtack), 0);
             chk("t4_no_to", 32'(timeout), 0);
             chk("t4_tgt_clr", 32'(cycle_tgt), 0);
    tick(2);

    // Ready on the timeout edge: ack wins
    LDS_n = 1'b0; tgt_sel = 5'b00100; AS_n = 1'b0;
    tick(13); chk("t5_data", 32'(z2_state), 2);
    tgt_ready = 5'b00100;
    tick();  chk("t5_dtack", 32'(dtack), 1);
             chk("t5_no_to", 32'(timeout), 0);
             chk("t5_end", 32'(z2_state), 3);
    AS_n = 1'b1; LDS_n = 1'b1; tgt_sel = '0; tgt_ready = '0;
    tick(3); chk("t5_idle", 32'(z2_state), 0);
    tick(2);

    // Async reset while DTACK_n driven
    UDS_n = 1'b0; tgt_sel = 5'b00010; tgt_ready = 5'b00010; AS_n = 1'b0;
    tick(6); chk("t6_end", 32'(z2_state), 3);
             chk("t6_pin_low", 32'(dtack_n_w), 0);
    RESET_n = 1'b0;
    #1;      chk("t6_pin_z", 32'(dtack_n_w), 1);
             chk("t6_idle", 32'(z2_state), 0);
             chk("t6_dtack", 32'(dtack), 0);
             chk("t6_tgt", 32'(cycle_tgt), 0);
    AS_n = 1'b1; UDS_n = 1'b1; tgt_sel = '0; tgt_ready = '0;
    #2 RESET_n = 1'b1;
    tick(3); chk("t6_post_idle", 32'(z2_state), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
